// File: rtl/square_osc.sv
// square_osc: 50% duty square-wave tone generator.
// Periods change only at half-period boundaries; release finishes the current period.
module square_osc #(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [BW-1:0] halfCntPeriod_i,
    input  logic          gate_i,
    output logic          wave_o,
    output logic          cycle_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] per, per_n;
    logic [BW-1:0] cnt, cnt_n;
    logic          wave_n;
    logic          cycle_n;
    logic          boundary;
    state_t        gate_st;

    assign boundary = (cnt == per - BW'(1));
    assign gate_st  = gate_i ? RUN : RELEASE;
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            per     <= '0;
            cnt     <= '0;
            wave_o  <= 1'b0;
            cycle_o <= 1'b0;
        end else begin
            state   <= state_n;
            per     <= per_n;
            cnt     <= cnt_n;
            wave_o  <= wave_n;
            cycle_o <= cycle_n;
        end
    end

    always_comb begin
        state_n = state;
        per_n   = per;
        cnt_n   = cnt;
        wave_n  = wave_o;
        cycle_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n  = '0;
                wave_n = 1'b0;
                if (gate_i && (halfCntPeriod_i != '0)) begin
                    per_n   = halfCntPeriod_i;
                    wave_n  = 1'b1;
                    cycle_n = 1'b1;
                    state_n = RUN;
                end
            end
            RUN, RELEASE: begin
                state_n = gate_st;
                if (en_i) begin
                    if (boundary) begin
                        per_n = halfCntPeriod_i;
                        cnt_n = '0;
                        if (halfCntPeriod_i == '0) begin
                            wave_n  = 1'b0;
                            state_n = IDLE;
                        end else if (wave_o) begin
                            wave_n = 1'b0;
                        end else if (state == RELEASE && !gate_i) begin
                            // released note ends here instead of starting a new period
                            wave_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            wave_n  = 1'b1;
                            cycle_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                wave_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_square_osc.sv
// tb_square_osc: directed vector table plus hand-written sequences
// for period change, release, gated ticks and reset.
module tb_square_osc;

    localparam int BW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic [BW-1:0] halfCntPeriod_i = '0;
    logic          gate_i = 1'b0;
    logic          wave_o;
    logic          cycle_o;
    logic          busy_o;

    int total = 0;
    int bad = 0;

    square_osc #(.BW(BW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .en_i            (en_i),
        .halfCntPeriod_i (halfCntPeriod_i),
        .gate_i          (gate_i),
        .wave_o          (wave_o),
        .cycle_o         (cycle_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic          en;
        logic          gate;
        logic [BW-1:0] hcp;
        logic          w;
        logic          c;
        logic          b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic g, int p,
                                logic w, logic c, logic b);
        vec_t v;
        v.rst = r; v.en = e; v.gate = g; v.hcp = BW'(p);
        v.w = w; v.c = c; v.b = b;
        return v;
    endfunction

    task automatic tick(input logic r, input logic e, input logic g, input int p);
        rst_i = r;
        en_i = e;
        gate_i = g;
        halfCntPeriod_i = BW'(p);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic w, input logic c, input logic b);
        total++;
        if (wave_o !== w || cycle_o !== c || busy_o !== b) begin
            bad++;
            $display("FAIL %s[%0d] got w/c/b=%b%b%b want=%b%b%b",
                     name, idx, wave_o, cycle_o, busy_o, w, c, b);
        end
    endtask

    initial begin
        // reset
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 3, 0, 0, 0));
        // P=3 continuous: 111000 repeating, cycle every 6
        tbl.push_back(mk(0, 1, 1, 3, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 1, 1, 1));
        // P=1: toggle every clock
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1));
        // release with P=1: finish low half then idle
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        // zero period never starts
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].gate, int'(tbl[i].hcp));
            chk("table", i, tbl[i].w, tbl[i].c, tbl[i].b);
        end

        // period change 4 -> 2 during the first high half
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick(0, 1, 1, (i <= 2) ? 4 : 2);
            chk("perchg", i, (i <= 4) || (i == 7) || (i == 8),
                (i == 1) || (i == 7), 1'b1);
        end

        // P=5 gate drop two clocks into high half
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            tick(0, 1, i < 3, 5);
            chk("release", i, i <= 5, i == 1, i <= 10);
        end

        // P=5 gate returns during the release low half
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            tick(0, 1, (i < 3) || (i >= 9), 5);
            chk("regate", i, (i <= 5) || (i >= 11),
                (i == 1) || (i == 11), 1'b1);
        end

        // en every third clock, P=2: halves of 6 clocks
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 18; i++) begin
            tick(0, (i % 3) == 0, 1, 2);
            chk("gated_en", i, (i < 6) || (i >= 12 && i < 18),
                (i == 1) || (i == 12), 1'b1);
        end

        // reset mid-high half with P=7, then zero period stays idle
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, 1, 7);
            chk("pre_rst", i, 1'b1, i == 1, 1'b1);
        end
        tick(1, 1, 1, 7);
        chk("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, 1, 0);
            chk("zero_idle", i, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_osc.md
# square_osc

Square-wave tone generator directly downstream of the note-to-count converter. It consumes the registered half-period count (in `en_i` ticks) and produces a 50 % duty square wave for the audio output stage. It applies new periods only at half-period boundaries, so note changes are glitch-free. On gate release it finishes the current period before going silent.

## Interface
Parameters:
- `BW`, default 16: width of the half-period count and the internal tick counter.

Ports:
- `clk_i`, input, 1: system clock. This is the only clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `en_i`, input, 1: tick strobe (prescaled time base). The counter advances only when it is 1. Tie it to 1 for full-rate counting.
- `halfCntPeriod_i`, input, BW: half-period length in ticks. The value 0 means silence.
- `gate_i`, input, 1: note-on level. 1 means play, 0 means release.
- `wave_o`, input/output role: output, 1: square-wave output, registered.
- `cycle_o`, output, 1: one-`clk_i` pulse coincident with each rising edge of `wave_o`, registered.
- `busy_o`, output, 1: high whenever the state is not IDLE.

## Operation
- Internal registers:
  - `per` (BW): latched half-period.
  - `cnt` (BW): tick counter.
  - `state`: one of IDLE, RUN, RELEASE.
- IDLE:
  - Holds `wave_o=0` and `cnt=0`.
  - If `gate_i=1` and `halfCntPeriod_i!=0` on a clock edge (`en_i` not required): latch `per`, set `cnt=0`, `wave_o=1`, pulse `cycle_o`, and go to RUN.
  - If `gate_i=1` and `halfCntPeriod_i=0`: stay in IDLE.
- RUN, on an edge with `en_i=1`:
  - If `cnt == per-1` (half-period boundary):
    - Set `cnt=0` and toggle `wave_o`.
    - Re-latch `per` from `halfCntPeriod_i`.
    - If the toggle is 0→1, pulse `cycle_o`.
  - Otherwise, `cnt` increments by 1.
- RUN, on an edge with `en_i=0`: `cnt` and `wave_o` hold.
- RUN: `gate_i=0` sampled at any edge moves the state to RELEASE on that edge. The counter keeps running unchanged.
- RELEASE:
  - Counts exactly as RUN does.
  - At a 1→0 boundary: the toggle happens normally.
  - At the next 0→1 boundary: `wave_o` stays 0, no `cycle_o` pulse, `cnt=0`, and the state goes to IDLE.
  - If `gate_i=1` returns before that boundary: go back to RUN with no disturbance to `cnt`, `wave_o` or `per`.
- Zero period at a boundary: if the re-latched value is 0 in RUN or RELEASE, then on that boundary edge set `wave_o=0`, `cnt=0`, go to IDLE, and emit no `cycle_o`.
- Period change: `halfCntPeriod_i` is sampled only at IDLE→RUN and at boundaries. Changes between boundaries are ignored.
- Arithmetic:
  - The comparison `cnt == per-1` is done in BW bits. `per` is never 0 while in RUN or RELEASE, so there is no underflow.
  - With `per=1`, the wave toggles on every `en_i` tick.
  - With `per = 2^BW-1`, `cnt` reaches `2^BW-2` and then wraps to 0. `cnt` never overflows.
- Simultaneous events on one edge:
  - Boundary plus `gate_i` fall in RUN: the boundary action runs and the state becomes RELEASE.
  - Boundary plus `gate_i` rise in RELEASE: the wave toggles as in RUN (a rising edge is allowed) and the state becomes RUN.
- Reset has priority over everything, including mid-period: `state=IDLE`, `cnt=0`, `per=0`, `wave_o=0`, `cycle_o=0`, `busy_o=0`.

## Timing
- All outputs are registered, and all outputs are 0 after reset.
- IDLE start latency: `gate_i` sampled high at edge N gives `wave_o=1`, `cycle_o=1` and `busy_o=1` after edge N.
- `cycle_o` is high for exactly one `clk_i` cycle.
- With `en_i` held at 1 and latched period P:
  - `wave_o` is high for P clocks, then low for P clocks.
  - Full period is 2P clocks.
- With a gated `en_i`: each half period lasts exactly P `en_i` ticks.
- `busy_o` falls on the same edge that puts the state in IDLE.
- Release latency: from the `gate_i` fall, at most 2P ticks until IDLE. The last `wave_o` high phase is never truncated.

## Test plan
- Reset, then P=3, `en_i=1`, `gate_i=1` held: `wave_o` pattern is 111000 repeating, and `cycle_o` pulses every 6 clocks starting the cycle after the gate is sampled.
- P=4, then change the input to 2 at clock 2 of a high half: the current high half lasts 4 clocks, and all following halves last 2 clocks.
- P=5, drop `gate_i` 2 clocks into a high half: high completes to 5, low lasts 5, `wave_o` stays 0, `busy_o` falls at the boundary, and there is no extra `cycle_o`.
- During RELEASE (P=5, low half), reassert `gate_i`: `wave_o` rises at the normal boundary, `cycle_o` pulses, and the state is RUN.
- `en_i` every 3rd clock, P=2: each half lasts 6 clocks. Also P=1 with `en_i=1`: the wave toggles every clock.
- Assert `rst_i` mid-high-half with P=7: the next cycle has all outputs 0. Then with `halfCntPeriod_i=0` and `gate_i=1`: the block stays in IDLE with `wave_o=0`.
